uart_file_xfer: RTL and testbench

Host-side hardware engine for the UART console/file-transfer protocol the SoC firmware speaks. It is the synthesizable successor of the bench-side transfer tasks. It consumes bytes from a UART receive stream and passes console text through. On command bytes it either streams a memory region to the target, preceded by a size header, or captures a size-prefixed file from the target into memory. It sits between an `iob_uart` byte interface and a local RAM, and is parametrised in memory word width, address width and size-header length.

---
 rtl/uart_file_xfer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_file_xfer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_file_xfer.sv
`default_nettype none
// ============================================================================
// Module   : uart_file_xfer
// Purpose  : UART console passthrough plus size-prefixed file send/receive
//            between a UART byte stream and a local word-wide RAM.
// Revision : 1.0  initial release
// ============================================================================
module uart_file_xfer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SIZE_B = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [31:0]           cfg_send_size,
  output logic [7:0]            con_data,
  output logic                  con_valid,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [31:0]           rcv_size,
  output logic                  busy,
  output logic                  finished
);
  localparam int            NB        = DATA_W / 8;
  localparam int            LW        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(NB - 1);
  localparam logic [1:0]    HDR_LAST  = 2'(SIZE_B - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_SIZE, S_TX_RD, S_TX_LD, S_TX_DATA, S_RX_SIZE, S_RX_DATA, S_FINISHED
  } state_t;

  state_t              state_q;
  logic [1:0]          rst_sync_q;
  logic                rst_n_int;
  logic [31:0]         size_q, hdr_q, byte_cnt_q;
  logic [ADDR_W-1:0]   word_q;
  logic [DATA_W-1:0]   shift_q, pack_q;
  logic [NB-1:0]       mask_q;
  logic [LW-1:0]       lane_q;
  logic [1:0]          hdr_idx_q;
  logic                rx_ready_q, tx_valid_q, con_valid_q, mem_en_q, busy_q, finished_q;
  logic [7:0]          tx_data_q, con_data_q;
  logic [NB-1:0]       mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [31:0]         rcv_size_q;

  logic [31:0]         byte_cnt_d, hdr_d, rsize_d;
  logic [DATA_W-1:0]   shift_d, pack_d;
  logic [NB-1:0]       mask_d;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign byte_cnt_d = byte_cnt_q + 32'd1;
  assign hdr_d      = hdr_q >> 8;
  assign shift_d    = shift_q >> 8;

  always_comb begin
    rsize_d = rcv_size_q;
    pack_d  = pack_q;
    mask_d  = mask_q;
    for (int k = 0; k < SIZE_B; k++)
      if (hdr_idx_q == 2'(k)) rsize_d[8*k +: 8] = rx_data;
    for (int k = 0; k < NB; k++)
      if (lane_q == LW'(k)) begin
        pack_d[8*k +: 8] = rx_data;
        mask_d[k]        = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      hdr_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      pack_q      <= '0;
      mask_q      <= '0;
      lane_q      <= '0;
      hdr_idx_q   <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rcv_size_q  <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      con_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_ready_q) begin
            case (rx_data)
              8'h02: begin
                size_q     <= cfg_send_size;
                hdr_q      <= cfg_send_size >> 8;
                byte_cnt_q <= '0;
                word_q     <= '0;
                hdr_idx_q  <= '0;
                tx_data_q  <= cfg_send_size[7:0];
                tx_valid_q <= 1'b1;
                rx_ready_q <= 1'b0;
                busy_q     <= 1'b1;
                state_q    <= S_TX_SIZE;
              end
              8'h03: begin
                rcv_size_q <= '0;
                hdr_idx_q  <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_RX_SIZE;
              end
              8'h04: begin
                finished_q <= 1'b1;
                rx_ready_q <= 1'b0;
                state_q    <= S_FINISHED;
              end
              default: begin
                con_data_q  <= rx_data;
                con_valid_q <= 1'b1;
              end
            endcase
          end else begin
            rx_ready_q <= 1'b1;
          end
        end
        S_TX_SIZE: begin
          if (tx_valid_q && tx_ready) begin
            if (hdr_idx_q == HDR_LAST) begin
              tx_valid_q <= 1'b0;
              if (size_q == 32'd0) begin
                busy_q     <= 1'b0;
                rx_ready_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                mem_en_q   <= 1'b1;
                mem_addr_q <= word_q;
                state_q    <= S_TX_RD;
              end
            end else begin
              hdr_idx_q <= hdr_idx_q + 2'd1;
              tx_data_q <= hdr_q[7:0];
              hdr_q     <= hdr_d;
            end
          end
        end
        S_TX_RD: begin
          mem_en_q <= 1'b0;
          state_q  <= S_TX_LD;
        end
        S_TX_LD: begin
          tx_data_q  <= mem_rdata[7:0];
          shift_q    <= mem_rdata >> 8;
          tx_valid_q <= 1'b1;
          lane_q     <= '0;
          state_q    <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (tx_valid_q && tx_ready) begin
            byte_cnt_q <= byte_cnt_d;
            lane_q     <= lane_q + LW'(1);
            if (byte_cnt_d == size_q) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else if (lane_q == LANE_LAST) begin
              tx_valid_q <= 1'b0;
              word_q     <= word_q + ADDR_W'(1);
              mem_addr_q <= word_q + ADDR_W'(1);
              mem_en_q   <= 1'b1;
              state_q    <= S_TX_RD;
            end else begin
              tx_data_q <= shift_q[7:0];
              shift_q   <= shift_d;
            end
          end
        end
        S_RX_SIZE: begin
          if (rx_valid && rx_ready_q) begin
            rcv_size_q <= rsize_d;
            hdr_idx_q  <= hdr_idx_q + 2'd1;
            if (hdr_idx_q == HDR_LAST) begin
              if (rsize_d == 32'd0) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                byte_cnt_q <= '0;
                word_q     <= '0;
                lane_q     <= '0;
                pack_q     <= '0;
                mask_q     <= '0;
                state_q    <= S_RX_DATA;
              end
            end
          end
        end
        S_RX_DATA: begin
          // mem_en_q marks the write cycle; rx is stalled during it.
          if (mem_en_q) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= '0;
            word_q     <= word_q + ADDR_W'(1);
            lane_q     <= '0;
            pack_q     <= '0;
            mask_q     <= '0;
            rx_ready_q <= 1'b1;
            if (byte_cnt_q == rcv_size_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (rx_valid && rx_ready_q) begin
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            mask_q     <= mask_d;
            lane_q     <= lane_q + LW'(1);
            if (lane_q == LANE_LAST || byte_cnt_d == rcv_size_q) begin
              rx_ready_q  <= 1'b0;
              mem_en_q    <= 1'b1;
              mem_we_q    <= mask_d;
              mem_wdata_q <= pack_d;
              mem_addr_q  <= word_q;
            end
          end
        end
        S_FINISHED: begin
          rx_ready_q <= 1'b0;
          tx_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign con_data  = con_data_q;
  assign con_valid = con_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rcv_size  = rcv_size_q;
  assign busy      = busy_q;
  assign finished  = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_file_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_file_xfer
// Purpose  : Self-checking bench for uart_file_xfer (32-bit/4-byte-header and
//            16-bit/2-byte-header instances) against a byte-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_file_xfer;
  localparam int NB = 4;
  localparam int SB = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] cfg_send_size = '0;
  logic [31:0] mem_rdata = '0;
  logic        rx_ready, tx_valid, con_valid, mem_en, busy, finished;
  logic [7:0]  tx_data, con_data;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, rcv_size;

  logic        resetn2 = 1'b0;
  logic [7:0]  rx_data2 = '0;
  logic        rx_valid2 = 1'b0;
  logic        tx_ready2 = 1'b1;
  logic [31:0] cfg_send_size2 = '0;
  logic [15:0] mem_rdata2 = '0;
  logic        rx_ready2, tx_valid2, con_valid2, mem_en2, busy2, finished2;
  logic [7:0]  tx_data2, con_data2;
  logic [1:0]  mem_we2;
  logic [15:0] mem_addr2, mem_wdata2;
  logic [31:0] rcv_size2;

  uart_file_xfer #(.DATA_W(32), .ADDR_W(16), .SIZE_B(4)) u_dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cfg_send_size(cfg_send_size),
    .con_data(con_data), .con_valid(con_valid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rcv_size(rcv_size),
    .busy(busy), .finished(finished));

  uart_file_xfer #(.DATA_W(16), .ADDR_W(16), .SIZE_B(2)) u_dut16 (
    .clk(clk), .resetn(resetn2), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .cfg_send_size(cfg_send_size2),
    .con_data(con_data2), .con_valid(con_valid2), .mem_en(mem_en2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .rcv_size(rcv_size2),
    .busy(busy2), .finished(finished2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [15:0] addr; logic [3:0] we; logic [31:0] data; } wr_t;

  logic [31:0] mem [0:63];
  logic [7:0]  txq[$];
  logic [7:0]  conq[$];
  wr_t         wrq[$];
  wr_t         wrq2[$];
  int          cyc = 0, rd_count = 0, rd_cyc = -10;
  int          last_tx_cyc = 0, last_wr_cyc = 0, last_rx_cyc = 0, busy_mode = 0;
  logic        prev_tv = 1'b0, prev_tr = 1'b0, prev_busy = 1'b0, pend = 1'b0;
  logic [7:0]  prev_td = '0;
  logic [15:0] paddr = '0;
  bit          bp_en = 1'b0;

  always @(posedge clk) begin
    #1;
    tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Environment: RAM with one-cycle read latency (garbage otherwise) and monitors.
  always @(negedge clk) begin
    cyc++;
    mem_rdata = pend ? mem[paddr[5:0]] : 32'hDEAD_BEEF;
    pend  = mem_en && (mem_we == 4'h0);
    paddr = mem_addr;
    if (mem_en && mem_we == 4'h0) begin
      rd_count++;
      rd_cyc = cyc;
    end
    if (mem_en && mem_we != 4'h0) begin
      wrq.push_back('{addr: mem_addr, we: mem_we, data: mem_wdata});
      last_wr_cyc = cyc;
      chk("rx_ready_low_in_write", rx_ready, 1'b0);
    end
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      last_tx_cyc = cyc;
    end
    if (rx_valid && rx_ready) last_rx_cyc = cyc;
    if (con_valid) conq.push_back(con_data);
    if (cyc == rd_cyc + 2) chk("tx_valid_2cyc_after_read", tx_valid, 1'b1);
    if (prev_tv && !prev_tr) begin
      chk("tx_valid_held", tx_valid, 1'b1);
      chk("tx_data_held", tx_data, prev_td);
    end
    if (prev_busy && !busy) begin
      if (busy_mode == 1) chk("busy_drop_after_last_tx", cyc - last_tx_cyc, 1);
      if (busy_mode == 2) chk("busy_drop_after_last_wr", cyc - last_wr_cyc, 1);
      if (busy_mode == 3) chk("busy_drop_after_hdr", cyc - last_rx_cyc, 1);
    end
    prev_tv   = tx_valid;
    prev_tr   = tx_ready;
    prev_td   = tx_data;
    prev_busy = busy;
  end

  always @(negedge clk)
    if (mem_en2 && mem_we2 != 2'b00)
      wrq2.push_back('{addr: mem_addr2, we: {2'b00, mem_we2}, data: {16'h0, mem_wdata2}});

  task automatic rx_put(input bit two, input logic [7:0] b);
    int n = 0;
    if (two) begin rx_data2 = b; rx_valid2 = 1'b1; end
    else     begin rx_data  = b; rx_valid  = 1'b1; end
    @(negedge clk);
    while (!(two ? rx_ready2 : rx_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_byte_accepted", two ? rx_ready2 : rx_ready, 1'b1);
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  // Called at a negedge; returns at posedge+1.
  task automatic wait_idle(input bit two, input int budget);
    int n = 0;
    while ((two ? busy2 : busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cleared", two ? busy2 : busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_send_byte(input int unsigned s, input int i);
    if (i < SB) return 8'(s >> (8 * i));
    return 8'(mem[(i - SB) / NB] >> (8 * ((i - SB) % NB)));
  endfunction

  task automatic do_send(input int unsigned s, input bit bp, input int exp_reads);
    txq.delete();
    rd_count      = 0;
    busy_mode     = 1;
    bp_en         = bp;
    cfg_send_size = s;
    rx_put(1'b0, 8'h02);
    @(negedge clk);
    chk("busy_after_send_cmd", busy, 1'b1);
    wait_idle(1'b0, 2000);
    bp_en = 1'b0;
    chk("tx_byte_count", txq.size(), SB + s);
    for (int i = 0; i < txq.size() && i < SB + int'(s); i++)
      chk("tx_byte", txq[i], exp_send_byte(s, i));
    chk("read_count", rd_count, exp_reads);
  endtask

  task automatic do_recv(input logic [7:0] d[$], input int exp_writes);
    int unsigned n;
    logic [3:0]  m;
    logic [31:0] dd, bm;
    n = d.size();
    wrq.delete();
    rd_count  = 0;
    busy_mode = (n == 0) ? 3 : 2;
    rx_put(1'b0, 8'h03);
    @(negedge clk);
    chk("busy_after_recv_cmd", busy, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < SB; k++) rx_put(1'b0, 8'(n >> (8 * k)));
    foreach (d[i]) rx_put(1'b0, d[i]);
    @(negedge clk);
    wait_idle(1'b0, 200);
    chk("rcv_size", rcv_size, n);
    chk("write_count", wrq.size(), exp_writes);
    chk("no_reads_in_recv", rd_count, 0);
    for (int w = 0; w < wrq.size() && w < exp_writes; w++) begin
      m  = '0;
      dd = '0;
      bm = '0;
      for (int l = 0; l < NB; l++)
        if (w * NB + l < int'(n)) begin
          m[l]         = 1'b1;
          dd[8*l +: 8] = d[w * NB + l];
          bm[8*l +: 8] = 8'hFF;
        end
      chk("wr_addr", wrq[w].addr, w);
      chk("wr_mask", wrq[w].we, m);
      chk("wr_data", wrq[w].data & bm, dd);
    end
  endtask

  typedef struct { bit is_send; int unsigned size; bit bp; int exp_ops; } vec_t;

  initial begin
    vec_t        vecs [9];
    logic [7:0]  dq[$];
    logic [7:0]  exp6 [10];
    wr_t         w2;

    vecs = '{'{1'b1, 6, 1'b0, 2}, '{1'b1, 0, 1'b0, 0}, '{1'b1, 9, 1'b1, 3},
             '{1'b1, 1, 1'b0, 1}, '{1'b1, 13, 1'b1, 4}, '{1'b0, 5, 1'b0, 2},
             '{1'b0, 0, 1'b0, 0}, '{1'b0, 8, 1'b0, 2}, '{1'b0, 3, 1'b0, 1}};
    exp6 = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk("in_reset_busy", busy, 1'b0);
    chk("in_reset_tx_valid", tx_valid, 1'b0);
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    resetn2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_rx_ready", rx_ready, 1'b1);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_rcv_size", rcv_size, 32'd0);
    chk("reset_finished", finished, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rx_ready_16", rx_ready2, 1'b1);
    @(posedge clk);
    #1;

    // Worked send example from the protocol description.
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h0000_6655;
    do_send(6, 1'b0, 2);
    for (int i = 0; i < 10 && i < txq.size(); i++) chk("send_example_byte", txq[i], exp6[i]);

    // Worked receive example.
    dq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_recv(dq, 2);
    if (wrq.size() == 2) begin
      chk("recv_example_w0", {wrq[0].we, wrq[0].data}, {4'hF, 32'hDDCC_BBAA});
      chk("recv_example_w1", {wrq[1].we, wrq[1].data[7:0]}, {4'h1, 8'hEE});
    end

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    foreach (vecs[v]) begin
      if (vecs[v].is_send) begin
        do_send(vecs[v].size, vecs[v].bp, vecs[v].exp_ops);
      end else begin
        dq.delete();
        for (int i = 0; i < int'(vecs[v].size); i++) dq.push_back(8'($urandom));
        do_recv(dq, vecs[v].exp_ops);
      end
    end

    // Reset in the middle of a receive after two data bytes.
    busy_mode = 0;
    rx_put(1'b0, 8'h03);
    for (int k = 0; k < SB; k++) rx_put(1'b0, 8'(5 >> (8 * k)));
    rx_put(1'b0, 8'h5A);
    rx_put(1'b0, 8'hA5);
    wrq.delete();
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_tx_valid", tx_valid, 1'b0);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_con_valid", con_valid, 1'b0);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_mem_we", mem_we, 4'h0);
    chk("abort_mem_addr", mem_addr, 16'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_rcv_size", rcv_size, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_finished", finished, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_write", wrq.size(), 0);
    chk("abort_rx_ready_back", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    dq = '{8'h01, 8'h02, 8'h03};
    do_recv(dq, 1);

    // Same abort on the 16-bit / 2-byte-header instance, then a clean receive.
    rx_put(1'b1, 8'h03);
    rx_put(1'b1, 8'h05);
    rx_put(1'b1, 8'h00);
    rx_put(1'b1, 8'h77);
    @(negedge clk);
    chk("w16_rcv_size_mid", rcv_size2, 32'd5);
    @(posedge clk);
    #1;
    wrq2.delete();
    resetn2 = 1'b0;
    @(negedge clk);
    chk("w16_abort_outputs", {busy2, mem_en2, mem_we2, rcv_size2, tx_valid2, con_valid2}, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    resetn2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("w16_no_write", wrq2.size(), 0);
    chk("w16_rx_ready_back", rx_ready2, 1'b1);
    @(posedge clk);
    #1;
    rx_put(1'b1, 8'h03);
    rx_put(1'b1, 8'h03);
    rx_put(1'b1, 8'h00);
    rx_put(1'b1, 8'hA1);
    rx_put(1'b1, 8'hB2);
    rx_put(1'b1, 8'hC3);
    @(negedge clk);
    wait_idle(1'b1, 50);
    chk("w16_rcv_size", rcv_size2, 32'd3);
    chk("w16_write_count", wrq2.size(), 2);
    if (wrq2.size() == 2) begin
      w2 = wrq2[0];
      chk("w16_w0", {w2.addr, w2.we, w2.data}, {16'd0, 4'h3, 32'h0000_B2A1});
      w2 = wrq2[1];
      chk("w16_w1", {w2.addr, w2.we, w2.data[7:0]}, {16'd1, 4'h1, 8'hC3});
    end

    // Console passthrough, then terminate with 0x04.
    conq.delete();
    rx_put(1'b0, 8'h48);
    @(negedge clk);
    chk("con_valid_pulse", con_valid, 1'b1);
    chk("con_data_H", con_data, 8'h48);
    @(negedge clk);
    chk("con_valid_one_cycle", con_valid, 1'b0);
    @(posedge clk);
    #1;
    rx_put(1'b0, 8'h69);
    rx_put(1'b0, 8'h0A);
    rx_put(1'b0, 8'h04);
    @(negedge clk);
    chk("finished_set", finished, 1'b1);
    chk("con_count", conq.size(), 3);
    if (conq.size() == 3) chk("con_bytes", {conq[0], conq[1], conq[2]}, 24'h48690A);
    @(posedge clk);
    #1;
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("finished_rx_ready_low", rx_ready, 1'b0);
      chk("finished_tx_valid_low", tx_valid, 1'b0);
    end
    chk("finished_busy_low", busy, 1'b0);
    chk("finished_sticky", finished, 1'b1);
    rx_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
